// File: rtl/rf_write_ctrl.sv
// rtl/rf_write_ctrl.sv - register file write-port controller with 2-entry load FIFO
// Read-port forwarding of the in-flight write is built only when RF_WR_FWD_EN is defined.
module rf_write_ctrl #(
  parameter int DW = 64,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_vld,
  input  logic [0:AW-1] alu_rD,
  input  logic [0:2]    alu_ppp,
  input  logic [0:DW-1] alu_data,
  input  logic          ld_vld,
  output logic          ld_rdy,
  input  logic [0:AW-1] ld_rD,
  input  logic [0:2]    ld_ppp,
  input  logic [0:DW-1] ld_data,
  output logic          wrEn,
  output logic [0:AW-1] rD,
  output logic [0:2]    ppp,
  output logic [0:DW-1] d_in,
  input  logic [0:AW-1] rA,
  input  logic [0:AW-1] rB,
  input  logic [0:DW-1] d_out1,
  input  logic [0:DW-1] d_out2,
  output logic [0:DW-1] fwd_out1,
  output logic [0:DW-1] fwd_out2
);

  logic [1:0]    count_q, count_d;
  logic          wptr_q, wptr_d, rptr_q, rptr_d;
  logic [0:AW-1] f_rd_q [0:1];
  logic [0:2]    f_ppp_q [0:1];
  logic [0:DW-1] f_data_q [0:1];

  logic          wr_en_q, wr_en_d;
  logic [0:AW-1] rd_q, rd_d;
  logic [0:2]    ppp_q, ppp_d;
  logic [0:DW-1] data_q, data_d;

  logic push, pop;

  assign ld_rdy = (count_q != 2'd2);

  // The pop reads the head as it stood at the start of the cycle, so a
  // same-cycle push into an empty FIFO can never reach the output directly.
  always_comb begin
    push    = ld_vld && ld_rdy;
    pop     = !alu_vld && (count_q != 2'd0);
    wptr_d  = push ? ~wptr_q : wptr_q;
    rptr_d  = pop ? ~rptr_q : rptr_q;
    count_d = count_q;
    wr_en_d = 1'b0;
    rd_d    = rd_q;
    ppp_d   = ppp_q;
    data_d  = data_q;
    if (alu_vld) begin
      wr_en_d = 1'b1;
      rd_d    = alu_rD;
      ppp_d   = alu_ppp;
      data_d  = alu_data;
    end else if (pop) begin
      wr_en_d = 1'b1;
      rd_d    = f_rd_q[rptr_q];
      ppp_d   = f_ppp_q[rptr_q];
      data_d  = f_data_q[rptr_q];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 2'd0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      wr_en_q <= 1'b0;
      rd_q    <= '0;
      ppp_q   <= '0;
      data_q  <= '0;
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      wr_en_q <= wr_en_d;
      rd_q    <= rd_d;
      ppp_q   <= ppp_d;
      data_q  <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      f_rd_q[wptr_q]   <= ld_rD;
      f_ppp_q[wptr_q]  <= ld_ppp;
      f_data_q[wptr_q] <= ld_data;
    end
  end

  assign wrEn = wr_en_q;
  assign rD   = rd_q;
  assign ppp  = ppp_q;
  assign d_in = data_q;

`ifdef RF_WR_FWD_EN
  // Byte k of the word is bits [8k:8k+7]; mask bit k set means byte k is written.
  function automatic logic [0:7] lane_mask(input logic [0:2] p);
    case (p)
      3'b000:  lane_mask = 8'b1111_1111;
      3'b001:  lane_mask = 8'b1111_0000;
      3'b010:  lane_mask = 8'b0000_1111;
      3'b011:  lane_mask = 8'b1010_1010;
      3'b100:  lane_mask = 8'b0101_0101;
      default: lane_mask = 8'b0000_0000;
    endcase
  endfunction

  logic [0:7] fwd_mask;
  logic       hit1, hit2;

  always_comb begin
    fwd_mask = lane_mask(ppp_q);
    hit1     = wr_en_q && (rd_q == rA);
    hit2     = wr_en_q && (rd_q == rB);
    fwd_out1 = d_out1;
    fwd_out2 = d_out2;
    for (int b = 0; b < DW / 8; b++) begin
      if (hit1 && fwd_mask[b]) fwd_out1[8*b +: 8] = data_q[8*b +: 8];
      if (hit2 && fwd_mask[b]) fwd_out2[8*b +: 8] = data_q[8*b +: 8];
    end
  end
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^{rA, rB};
  assign fwd_out1 = d_out1;
  assign fwd_out2 = d_out2;
`endif

endmodule

// File: tb/tb_rf_write_ctrl.sv
// tb/tb_rf_write_ctrl.sv - randomized model-checked bench for rf_write_ctrl
// Directed cases pin literal values; a queue-based model is compared every cycle.
module tb_rf_write_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_vld;
  logic [0:4]  alu_rD;
  logic [0:2]  alu_ppp;
  logic [0:63] alu_data;
  logic        ld_vld;
  logic        ld_rdy;
  logic [0:4]  ld_rD;
  logic [0:2]  ld_ppp;
  logic [0:63] ld_data;
  logic        wrEn;
  logic [0:4]  rD;
  logic [0:2]  ppp;
  logic [0:63] d_in;
  logic [0:4]  rA, rB;
  logic [0:63] d_out1, d_out2;
  logic [0:63] fwd_out1, fwd_out2;

  rf_write_ctrl #(.DW(64), .AW(5)) dut (
    .clk(clk), .reset(reset),
    .alu_vld(alu_vld), .alu_rD(alu_rD), .alu_ppp(alu_ppp), .alu_data(alu_data),
    .ld_vld(ld_vld), .ld_rdy(ld_rdy), .ld_rD(ld_rD), .ld_ppp(ld_ppp), .ld_data(ld_data),
    .wrEn(wrEn), .rD(rD), .ppp(ppp), .d_in(d_in),
    .rA(rA), .rB(rB), .d_out1(d_out1), .d_out2(d_out2),
    .fwd_out1(fwd_out1), .fwd_out2(fwd_out2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [2:0]  p;
    logic [63:0] d;
  } ent_t;

  int   total = 0;
  int   bad = 0;
  bit   chk_en = 1'b0;
  ent_t src[$];
  ent_t mq[$];
  logic        m_wr;
  logic [4:0]  m_rd;
  logic [2:0]  m_ppp;
  logic [63:0] m_d;
  logic [0:63] rf [0:31];

  function automatic bit part(input logic [2:0] p, input int k);
    case (p)
      3'd0:    return 1'b1;
      3'd1:    return k < 4;
      3'd2:    return k >= 4;
      3'd3:    return (k % 2) == 0;
      3'd4:    return (k % 2) == 1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [0:63] merge(input logic [0:63] old, input logic [0:63] nw,
                                        input logic [2:0] p);
    logic [0:63] r;
    r = old;
    for (int k = 0; k < 8; k++) if (part(p, k)) r[8*k +: 8] = nw[8*k +: 8];
    return r;
  endfunction

  function automatic logic [0:63] exp_fwd(input logic [0:63] raw, input logic [4:0] ra);
    logic [0:63] r;
    r = raw;
`ifdef RF_WR_FWD_EN
    if (m_wr && m_rd == ra) r = merge(raw, m_d, m_ppp);
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural register file the DUT writes into.
  assign d_out1 = rf[rA];
  assign d_out2 = rf[rB];
  always @(posedge clk) if (wrEn === 1'b1) rf[rD] <= merge(rf[rD], d_in, ppp);

  // Reference model: a queue of waiting loads and the registered write stage.
  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_wr = 1'b0; m_rd = '0; m_ppp = '0; m_d = '0;
    end else begin
      bit   acc;
      ent_t e;
      acc = ld_vld && (mq.size() < 2);
      e   = '{rd: ld_rD, p: ld_ppp, d: ld_data};
      if (alu_vld) begin
        m_wr = 1'b1; m_rd = alu_rD; m_ppp = alu_ppp; m_d = alu_data;
      end else if (mq.size() > 0) begin
        ent_t h;
        h = mq.pop_front();
        m_wr = 1'b1; m_rd = h.rd; m_ppp = h.p; m_d = h.d;
      end else begin
        m_wr = 1'b0;
      end
      if (acc) mq.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("wrEn", wrEn, m_wr);
      chk("rD", rD, m_rd);
      chk("ppp", ppp, m_ppp);
      chk("d_in", d_in, m_d);
      chk("ld_rdy", ld_rdy, mq.size() < 2);
      chk("fwd_out1", fwd_out1, exp_fwd(d_out1, rA));
      chk("fwd_out2", fwd_out2, exp_fwd(d_out2, rB));
    end
  end

  task automatic present();
    if (src.size() > 0) begin
      ld_vld = 1'b1; ld_rD = src[0].rd; ld_ppp = src[0].p; ld_data = src[0].d;
    end else begin
      ld_vld = 1'b0;
    end
  endtask

  task automatic step();
    bit acc;
    acc = ld_vld && ld_rdy;
    @(posedge clk);
    #1;
    if (acc && src.size() > 0) void'(src.pop_front());
    present();
  endtask

  task automatic alu(input bit v, input logic [4:0] r, input logic [2:0] p, input logic [63:0] d);
    alu_vld = v; alu_rD = r; alu_ppp = p; alu_data = d;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    reset = 1'b1; alu_vld = 1'b0; alu_rD = '0; alu_ppp = '0; alu_data = '0;
    ld_vld = 1'b0; ld_rD = '0; ld_ppp = '0; ld_data = '0; rA = '0; rB = '0;
    step(); step();
    chk_en = 1'b1;
    chk("reset_wrEn", wrEn, 0);
    chk("reset_rD", rD, 0);
    chk("reset_ppp", ppp, 0);
    chk("reset_d_in", d_in, 0);
    chk("reset_ld_rdy", ld_rdy, 1);
    reset = 1'b0;

    // ALU write latency and commit.
    alu(1, 3, 0, 64'd1777777777);
    step();
    chk("alu_wrEn", wrEn, 1);
    chk("alu_rD", rD, 3);
    chk("alu_d_in", d_in, 64'd1777777777);
    alu(0, 0, 0, 0);
    step();
    rA = 5'd3;
    #1;
    chk("alu_readback", d_out1, 64'd1777777777);

    // ALU priority with load backpressure.
    src.push_back('{rd: 5'd1, p: 3'd0, d: 64'hA1});
    src.push_back('{rd: 5'd2, p: 3'd0, d: 64'hA2});
    src.push_back('{rd: 5'd4, p: 3'd0, d: 64'hA4});
    alu(1, 9, 0, 64'h99);
    present();
    step(); step();
    chk("bp_ld_rdy_low", ld_rdy, 0);
    step(); step();
    alu(0, 0, 0, 0);
    step();
    chk("bp_first_load", {wrEn, rD}, {1'b1, 5'd1});
    step();
    chk("bp_second_load", {wrEn, rD}, {1'b1, 5'd2});
    step();
    chk("bp_third_load", {wrEn, rD}, {1'b1, 5'd4});
    step(); step();

    // Even-byte partial load over an all-ones register.
    alu(1, 2, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    alu(0, 0, 0, 0);
    step();
    rA = 5'd2;
    src.push_back('{rd: 5'd2, p: 3'd3, d: 64'h0});
    present();
    step();
    chk("ld_lat_not_yet", wrEn, 0);
    step();
    chk("ld_lat_wrEn", wrEn, 1);
`ifdef RF_WR_FWD_EN
    chk("even_merge", fwd_out1, 64'h00FF_00FF_00FF_00FF);
`else
    chk("even_raw", fwd_out1, 64'hFFFF_FFFF_FFFF_FFFF);
`endif
    step();

    // Odd-byte partial load over a zero register.
    alu(1, 5, 0, 64'h0);
    step();
    alu(0, 0, 0, 0);
    step();
    rB = 5'd5;
    src.push_back('{rd: 5'd5, p: 3'd4, d: 64'h1111_1111_1111_1111});
    present();
    step(); step();
`ifdef RF_WR_FWD_EN
    chk("odd_merge", fwd_out2, 64'h0011_0011_0011_0011);
`else
    chk("odd_raw", fwd_out2, 64'h0);
`endif
    step();

    // Reset with two loads queued behind the ALU.
    alu(1, 7, 0, 64'h77);
    src.push_back('{rd: 5'd10, p: 3'd0, d: 64'hB0});
    src.push_back('{rd: 5'd11, p: 3'd0, d: 64'hB1});
    present();
    step(); step();
    chk("rq_full", ld_rdy, 0);
    src.delete();
    present();
    alu(0, 0, 0, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rq_no_write", wrEn, 0);
      chk("rq_empty", ld_rdy, 1);
    end

    // Randomized traffic on a few registers so forwarding hits often.
    for (int c = 0; c < 1500; c++) begin
      alu($urandom_range(0, 9) < 4, 5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
          {$urandom, $urandom});
      if (src.size() < 4 && $urandom_range(0, 9) < 5)
        src.push_back('{rd: 5'($urandom_range(0, 3)), p: 3'($urandom_range(0, 7)),
                        d: {$urandom, $urandom}});
      present();
      rA = 5'($urandom_range(0, 3));
      rB = 5'($urandom_range(0, 3));
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;
    alu(0, 0, 0, 0);
    src.delete();
    present();
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
